// File: rtl/fetch_queue.sv
// Instruction fetch stage: credit-limited prefetch from a variable-latency
// instruction memory, delay-slot-aware redirect and PC-tagged wrong-path discard.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        jump_branch,
  input  logic        jump_target,
  input  logic        jump_reg,
  input  logic [31:0] jr_pc,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   r_out_addr [DEPTH];
  logic [AW-1:0] r_out_wp, r_out_rp;
  logic [CW-1:0] r_out_cnt;
  logic [31:0]   r_q_tag  [DEPTH];
  logic [31:0]   r_q_word [DEPTH];
  logic [AW-1:0] r_q_wp, r_q_rp;
  logic [CW-1:0] r_q_cnt;

  logic [31:0] r_fpc, r_exp, r_ds_pc, r_redir_tgt;
  logic        r_redir_pend, r_jmp_after_gnt;
  logic [31:0] r_pc, r_instr;
  logic        r_instr_valid;

  logic [CW:0] w_credits;
  logic        w_rv, w_q_empty, w_src_valid, w_match, w_drop, w_load, w_consume;
  logic        w_q_pop, w_q_push, w_grant, w_advance, w_redirect, w_ds_now;
  logic [31:0] w_src_tag, w_src_word, w_pc_plus4, w_br_off, w_target;

  assign w_credits = {1'b0, r_out_cnt} + {1'b0, r_q_cnt};
  assign imem_req  = ~rst & (w_credits < (CW+1)'(DEPTH));
  assign imem_addr = r_fpc;
  assign w_grant   = imem_req & imem_gnt;

  // A response is tagged with the oldest outstanding address.
  assign w_rv        = imem_rvalid & (r_out_cnt != '0);
  assign w_q_empty   = (r_q_cnt == '0);
  assign w_src_valid = ~w_q_empty | w_rv;
  assign w_src_tag   = w_q_empty ? r_out_addr[r_out_rp] : r_q_tag[r_q_rp];
  assign w_src_word  = w_q_empty ? imem_rdata : r_q_word[r_q_rp];

  assign w_advance = ~r_instr_valid | ~stall;
  assign w_match   = w_src_valid & (w_src_tag == r_exp);
  assign w_drop    = w_src_valid & ~w_match;
  assign w_load    = w_match & w_advance;
  assign w_consume = w_drop | w_load;
  assign w_q_pop   = ~w_q_empty & w_consume;
  assign w_q_push  = w_rv & ~(w_q_empty & w_consume);

  assign w_redirect = r_instr_valid & ~stall & (jump_reg | jump_target | jump_branch);
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  // Delay slot loaded in the very cycle its branch resolves.
  assign w_ds_now   = w_load & w_redirect & (w_src_tag == w_pc_plus4);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_target = w_pc_plus4 + w_br_off;
    if (jump_reg)         w_target = jr_pc;
    else if (jump_target) w_target = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_wp        <= '0;
      r_out_rp        <= '0;
      r_out_cnt       <= '0;
      r_q_wp          <= '0;
      r_q_rp          <= '0;
      r_q_cnt         <= '0;
      r_fpc           <= RESET_PC;
      r_exp           <= RESET_PC;
      r_ds_pc         <= RESET_PC;
      r_redir_tgt     <= RESET_PC;
      r_redir_pend    <= 1'b0;
      r_jmp_after_gnt <= 1'b0;
      r_pc            <= RESET_PC;
      r_instr         <= '0;
      r_instr_valid   <= 1'b0;
    end else begin
      if (w_grant) r_out_wp <= r_out_wp + AW'(1);
      if (w_rv)    r_out_rp <= r_out_rp + AW'(1);
      r_out_cnt <= r_out_cnt + CW'(w_grant) - CW'(w_rv);

      if (w_q_push) r_q_wp <= r_q_wp + AW'(1);
      if (w_q_pop)  r_q_rp <= r_q_rp + AW'(1);
      r_q_cnt <= r_q_cnt + CW'(w_q_push) - CW'(w_q_pop);

      if (w_load) begin
        r_pc          <= w_src_tag;
        r_instr       <= w_src_word;
        r_instr_valid <= 1'b1;
        if (w_ds_now) begin
          r_exp <= w_target;
        end else if (r_redir_pend && (w_src_tag == r_ds_pc)) begin
          r_exp        <= r_redir_tgt;
          r_redir_pend <= 1'b0;
        end else begin
          r_exp <= w_src_tag + 32'd4;
        end
      end else if (w_advance) begin
        r_instr_valid <= 1'b0;
      end

      if (w_redirect) begin
        r_ds_pc      <= w_pc_plus4;
        r_redir_tgt  <= w_target;
        r_redir_pend <= ~w_ds_now;
      end

      // An ungranted delay-slot request must still go out before the target.
      if (w_redirect) begin
        if ((r_fpc == w_pc_plus4) && !w_grant) begin
          r_jmp_after_gnt <= 1'b1;
        end else begin
          r_fpc           <= w_target;
          r_jmp_after_gnt <= 1'b0;
        end
      end else if (w_grant) begin
        r_fpc           <= r_jmp_after_gnt ? r_redir_tgt : r_fpc + 32'd4;
        r_jmp_after_gnt <= 1'b0;
      end
    end
  end

  // NOTE: storage arrays carry no reset; validity comes from the reset counters.
  always_ff @(posedge clk) begin
    if (w_grant) r_out_addr[r_out_wp] <= r_fpc;
    if (w_q_push) begin
      r_q_tag[r_q_wp]  <= r_out_addr[r_out_rp];
      r_q_word[r_q_wp] <= imem_rdata;
    end
  end

  assign pc          = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: per-cycle vector table for reset, streaming,
// stall and a taken branch, then sequences for JR, J, negative branch and reset.
module tb_fetch_queue;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_gnt, imem_rvalid;
  logic        stall, jump_branch, jump_target, jump_reg, instr_valid;
  logic [31:0] imem_addr, imem_rdata, jr_pc, pc, instr;

  always #5 clk = ~clk;

  fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .jump_branch(jump_branch), .jump_target(jump_target),
    .jump_reg(jump_reg), .jr_pc(jr_pc),
    .pc(pc), .instr(instr), .instr_valid(instr_valid)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct {
    logic rst, stall, jb;
    logic req; logic [31:0] addr;
    logic iv;  logic [31:0] pc;
  } vec_t;

  mreq_t       mq[$];
  logic [31:0] dlv[$], glog[$];
  int          cyc, lat, n_checks, n_fail;
  logic        gnt_en, blk_en, s_req, found;
  logic [31:0] blk_addr, s_addr;
  vec_t        tbl[16];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h1000_0004;  // beq +4 words
      32'h1000_0040: return 32'h0800_0100;  // j 0x100
      32'h1000_0400: return 32'h1000_FFFC;  // beq -4 words
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // One clock cycle: drive memory outputs mid-cycle, sample the request side,
  // then update the in-order memory model and the delivery log.
  task automatic cycle();
    logic        granted, adv;
    logic [31:0] gaddr;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq[0].addr);
    end
    imem_gnt = gnt_en && !(blk_en && imem_addr == blk_addr);
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    granted = imem_req & imem_gnt;
    gaddr   = imem_addr;
    adv     = !instr_valid || !stall;
    @(posedge clk);
    if (imem_rvalid) void'(mq.pop_front());
    if (rst) mq.delete();
    else if (granted) begin
      mq.push_back('{gaddr, cyc + lat});
      glog.push_back(gaddr);
    end
    cyc++;
    @(negedge clk);
    if (adv && instr_valid) dlv.push_back(pc);
  endtask

  task automatic run_until_dlv(input int n, input int budget);
    for (int k = 0; k < budget && dlv.size() < n; k++) cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // rst stall jb | req addr | iv pc   (outputs seen after the cycle)
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h04, 1'b1, 32'h00};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h04};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h08};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h08};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h08};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'h10};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h14};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h24, 1'b0, 32'h00};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h28, 1'b1, 32'h24};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h2C, 1'b1, 32'h28};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h30, 1'b1, 32'h2C};

    n_checks = 0; n_fail = 0; cyc = 0; lat = 1;
    gnt_en = 1'b1; blk_en = 1'b0; blk_addr = '0;
    rst = 1'b1; stall = 1'b0; jump_branch = 1'b0; jump_target = 1'b0; jump_reg = 1'b0;
    jr_pc = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    @(negedge clk);

    cycle();
    check("reset_req", s_req, 1'b0);
    check("reset_iv", instr_valid, 1'b0);
    check("reset_pc", pc, RESET_PC);
    check("reset_instr", instr, 32'h0);

    // Zero-wait memory: streaming, 3-cycle stall at pc=8, taken beq at 0x10.
    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst; stall = tbl[i].stall; jump_branch = tbl[i].jb;
      cycle();
      check($sformatf("vec%0d_req", i), s_req, tbl[i].req);
      if (tbl[i].req) check($sformatf("vec%0d_addr", i), s_addr, tbl[i].addr);
      check($sformatf("vec%0d_iv", i), instr_valid, tbl[i].iv);
      if (tbl[i].iv) begin
        check($sformatf("vec%0d_pc", i), pc, tbl[i].pc);
        check($sformatf("vec%0d_instr", i), instr, mem_word(tbl[i].pc));
      end
    end
    stall = 1'b0; jump_branch = 1'b0;

    // JR at 0x20 with 3-cycle memory while the delay slot request is held ungranted.
    rst = 1'b1; lat = 3; blk_en = 1'b1; blk_addr = 32'h24;
    cycle(); cycle();
    rst = 1'b0; found = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      cycle();
      if (instr_valid && pc == 32'h20) found = 1'b1;
    end
    check("jr_reach_0x20", found, 1'b1);
    check("jr_ds_pending_addr", imem_addr, 32'h24);
    jump_reg = 1'b1; jr_pc = 32'h0000_0400; glog.delete(); dlv.delete();
    cycle();
    jump_reg = 1'b0; blk_en = 1'b0;
    run_until_dlv(3, 60);
    check("jr_dlv0", dlv[0], 32'h24);
    check("jr_dlv1", dlv[1], 32'h400);
    check("jr_dlv2", dlv[2], 32'h404);
    check("jr_gnt0", glog[0], 32'h24);
    check("jr_gnt1", glog[1], 32'h400);

    // JR from 0x404 into 0x1000_0040, then J there, then a backward beq.
    check("pre_j_pc", pc, 32'h404);
    lat = 1; jump_reg = 1'b1; jr_pc = 32'h1000_0040; dlv.delete();
    cycle();
    jump_reg = 1'b0;
    run_until_dlv(2, 60);
    check("jr2_dlv0", dlv[0], 32'h408);
    check("jr2_dlv1", dlv[1], 32'h1000_0040);
    check("j_instr", instr, 32'h0800_0100);
    jump_target = 1'b1; dlv.delete();
    cycle();
    jump_target = 1'b0;
    run_until_dlv(2, 60);
    check("j_dlv0", dlv[0], 32'h1000_0044);
    check("j_dlv1", dlv[1], 32'h1000_0400);
    jump_branch = 1'b1; dlv.delete();
    cycle();
    jump_branch = 1'b0;
    run_until_dlv(2, 60);
    check("bneg_dlv0", dlv[0], 32'h1000_0404);
    check("bneg_dlv1", dlv[1], 32'h1000_03F4);

    // Reset with two requests in flight and a response landing in the reset cycle.
    lat = 3; found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (mq.size() == 2 && mq[0].due == cyc) begin found = 1'b1; break; end
      cycle();
    end
    check("rst_two_inflight", found, 1'b1);
    rst = 1'b1;
    cycle();
    check("rst_req0", s_req, 1'b0);
    check("rst_iv0", instr_valid, 1'b0);
    cycle();
    check("rst_req1", s_req, 1'b0);
    check("rst_iv1", instr_valid, 1'b0);
    rst = 1'b0; glog.delete(); dlv.delete();
    cycle();
    check("post_rst_req", s_req, 1'b1);
    check("post_rst_addr", s_addr, RESET_PC);
    run_until_dlv(2, 40);
    check("post_rst_dlv0", dlv[0], RESET_PC);
    check("post_rst_dlv1", dlv[1], RESET_PC + 32'd4);
    check("post_rst_gnt0", glog[0], RESET_PC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
